snn_rate_encoder: RTL

//  Upstream stimulus stage of the LIF neuron accelerator: holds one 8-bit

---
 rtl/snn_pkg.sv | 19 +
 rtl/snn_lfsr16.sv | 21 ++
 rtl/snn_rate_encoder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared encoder/neuron-core definitions: encoder FSM states, LFSR polynomial and seed.
// The Galois step function is shared so every LFSR user advances identically.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } enc_state_t;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/snn_lfsr16.sv
// 16-bit Galois LFSR that advances one step per enabled clock.
// The seed is loaded only by reset, so the sequence is fully deterministic.
module snn_lfsr16
    import snn_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= SEED;
        else if (en)
            q <= lfsr_step(q);
    end

endmodule

// File: rtl/snn_rate_encoder.sv
// Stochastic rate encoder: scans one channel per clock, comparing intensities with an LFSR.
// Defining ENC_SPIKE_CNT_EN adds the spk_cnt output (popcount of spk_vec).
module snn_rate_encoder
    import snn_pkg::*;
#(
    parameter int          N_CH      = 8,
    parameter int          IW        = 8,
    parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED,
    // One spare index bit so out-of-range channel numbers reach the discard logic
    localparam int         CHW       = $clog2(N_CH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [CHW-1:0]  ld_ch,
    input  logic [IW-1:0]   ld_val,
    input  logic            step,
    output logic            busy,
    output logic            spk_valid,
    input  logic            spk_ready,
    output logic [N_CH-1:0] spk_vec,
    output logic [7:0]      spk_ts
`ifdef ENC_SPIKE_CNT_EN
    ,
    output logic [$clog2(N_CH+1)-1:0] spk_cnt
`endif
);

    localparam int          IDXW     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int          CNTW     = $clog2(N_CH + 1);
    localparam logic [15:0] LOW_MASK = 16'((32'd1 << IW) - 32'd1);

    enc_state_t         state_reg, state_next;
    logic [IDXW-1:0]    idx_reg;
    logic [N_CH-1:0]    vec_reg;
    logic [7:0]         ts_reg;
    logic [CNTW-1:0]    cnt_reg;
    logic [IW-1:0]      intens [N_CH];
    logic [15:0]        lfsr_q;
    logic [15:0]        lfsr_next;
    logic               wr_en;
    logic               scan_last;
    logic               hit;

    assign wr_en     = (state_reg == IDLE) && ld_valid;
    assign scan_last = (idx_reg == IDXW'(N_CH - 1));
    assign lfsr_next = lfsr_step(lfsr_q);
    // The compare uses the value the LFSR is about to take this SCAN cycle
    assign hit       = (lfsr_next & LOW_MASK) < 16'(intens[idx_reg]);

    snn_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (state_reg == SCAN),
        .q   (lfsr_q)
    );

    // Per-channel intensity flops; indices >= N_CH match no channel and are dropped
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [IW-1:0] val_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                val_reg <= '0;
            else if (wr_en && (ld_ch == CHW'(gi)))
                val_reg <= ld_val;
        end

        assign intens[gi] = val_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (step)      state_next = SCAN;
            SCAN:    if (scan_last) state_next = OUT;
            OUT:     if (spk_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg <= '0;
            vec_reg <= '0;
            ts_reg  <= '0;
            cnt_reg <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (step) begin
                        idx_reg <= '0;
                        vec_reg <= '0;
                        cnt_reg <= '0;
                    end
                end
                SCAN: begin
                    vec_reg[idx_reg] <= hit;
                    cnt_reg          <= cnt_reg + CNTW'(hit);
                    idx_reg          <= scan_last ? '0 : idx_reg + IDXW'(1);
                end
                OUT: begin
                    if (spk_ready)
                        ts_reg <= ts_reg + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign ld_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign spk_valid = (state_reg == OUT);
    assign spk_vec   = vec_reg;
    assign spk_ts    = ts_reg;

`ifdef ENC_SPIKE_CNT_EN
    assign spk_cnt = cnt_reg;
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt_reg;
`endif

endmodule
